mmio_controller: RTL and testbench

Memory-mapped I/O controller between the processor's data-memory port, the data RAM, the button synchronizer and the VGA controller. It decodes loads and stores to the I/O address window and queues button events for the CPU. It double-buffers the sprite coordinate words, so the VGA controller only sees new coordinates at a vertical-blank boundary. It also holds the sticky game-done flag and a frame counter the game loop uses for pacing.

---
 rtl/mmio_pkg.sv | 25 ++
 rtl/mmio_controller_btn_fifo.sv | 80 ++++++++
 rtl/mmio_controller.sv | 133 +++++++++++++
 tb/tb_mmio_controller.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared address map, status bit positions and button code type for the MMIO controller.
package mmio_pkg;

  localparam logic [11:0] ADDR_BTN    = 12'd0;
  localparam logic [11:0] ADDR_DONE   = 12'd1;
  localparam logic [11:0] ADDR_COMMIT = 12'd2;
  localparam logic [11:0] ADDR_STATUS = 12'd3;
  localparam logic [11:0] ADDR_FRAME  = 12'd4;
  localparam logic [11:0] ADDR_X      = 12'd300;
  localparam logic [11:0] ADDR_Y      = 12'd400;

  localparam int unsigned ST_NONEMPTY = 0;
  localparam int unsigned ST_CNT_LSB  = 1;
  localparam int unsigned ST_OVF      = 5;
  localparam int unsigned ST_COMMIT   = 6;
  localparam int unsigned ST_DONE     = 7;

  typedef logic [2:0] btn_code_t;

  function automatic logic is_io_addr(input logic [11:0] a);
    return a inside {ADDR_BTN, ADDR_DONE, ADDR_COMMIT, ADDR_STATUS,
                     ADDR_FRAME, ADDR_X, ADDR_Y};
  endfunction

endpackage

// File: rtl/mmio_controller_btn_fifo.sv
// Button event store: circular DEPTH-entry queue with MMIO_BTN_FIFO_EN, otherwise a
// single-entry latch where a new code overwrites an unread one.
module btn_fifo
  import mmio_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  btn_code_t        din_i,
  output btn_code_t        dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

`ifdef MMIO_BTN_FIFO_EN
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  btn_code_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push-when-full still lands if popping.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
`else
  btn_code_t data_q;
  logic      valid_q;

  assign empty_o = ~valid_q;
  assign full_o  = valid_q;
  assign count_o = CNT_W'(valid_q);
  assign dout_o  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (push_i) begin
      data_q  <= din_i;
      valid_q <= 1'b1;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mmio_controller.sv
// MMIO decode, button queue, double-buffered sprite coordinates, game_done and frame counter.
// Queue depth behaviour selected by MMIO_BTN_FIFO_EN (see btn_fifo).
module mmio_controller
  import mmio_pkg::*;
#(
  parameter int unsigned BTN_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic        mem_read,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic [31:0] ram_q,
  output logic        ram_wren,
  output logic [31:0] q_dmem,
  input  logic [2:0]  button_code,
  input  logic        button_valid,
  input  logic        vblank_start,
  output logic [31:0] x_values,
  output logic [31:0] y_values,
  output logic        game_done
);

  localparam int unsigned CNT_W = $clog2(BTN_DEPTH + 1);

  logic             io_hit;
  logic             wr_done, wr_commit, wr_x, wr_y, rd_btn, rd_status;
  logic             btn_push, btn_drop, btn_empty, btn_full;
  btn_code_t        btn_head;
  logic [CNT_W-1:0] btn_count;
  logic [31:0]      status;

  logic        io_sel_q, io_sel_d;
  logic [31:0] io_rdata_q, io_rdata_d;
  logic [31:0] x_shadow_q, x_shadow_d, y_shadow_q, y_shadow_d;
  logic [31:0] x_values_q, x_values_d, y_values_q, y_values_d;
  logic [31:0] frame_q, frame_d;
  logic        done_q, done_d, commit_q, commit_d, ovf_q, ovf_d;

  assign io_hit    = is_io_addr(address_dmem);
  assign ram_wren  = wren & ~io_hit;
  assign wr_done   = wren & (address_dmem == ADDR_DONE) & data[0];
  assign wr_commit = wren & (address_dmem == ADDR_COMMIT);
  assign wr_x      = wren & (address_dmem == ADDR_X);
  assign wr_y      = wren & (address_dmem == ADDR_Y);
  assign rd_btn    = mem_read & (address_dmem == ADDR_BTN);
  assign rd_status = mem_read & (address_dmem == ADDR_STATUS);
  assign btn_push  = button_valid & (button_code != '0);
  assign btn_drop  = btn_push & btn_full & ~rd_btn;

  btn_fifo #(.DEPTH(BTN_DEPTH)) u_btn_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (btn_push),
    .pop_i   (rd_btn),
    .din_i   (button_code),
    .dout_o  (btn_head),
    .empty_o (btn_empty),
    .full_o  (btn_full),
    .count_o (btn_count)
  );

  // Count field is 4 bits wide; a full 16-deep queue reads back as 0 with nonempty set.
  always_comb begin
    status                     = '0;
    status[ST_NONEMPTY]        = ~btn_empty;
    status[ST_CNT_LSB +: 4]    = 4'(btn_count);
    status[ST_OVF]             = ovf_q;
    status[ST_COMMIT]          = commit_q;
    status[ST_DONE]            = done_q;
  end

  always_comb begin
    io_sel_d   = mem_read & io_hit;
    io_rdata_d = '0;
    case (address_dmem)
      ADDR_BTN:    io_rdata_d = btn_empty ? '0 : {29'b0, btn_head};
      ADDR_DONE:   io_rdata_d = {31'b0, done_q};
      ADDR_STATUS: io_rdata_d = status;
      ADDR_FRAME:  io_rdata_d = frame_q;
      ADDR_X:      io_rdata_d = x_shadow_q;
      ADDR_Y:      io_rdata_d = y_shadow_q;
      default:     io_rdata_d = '0;
    endcase

    x_shadow_d = wr_x ? data : x_shadow_q;
    y_shadow_d = wr_y ? data : y_shadow_q;
    x_values_d = x_values_q;
    y_values_d = y_values_q;
    // Commit copies the pre-write shadows; a commit write at vblank waits for the next one.
    if (vblank_start && commit_q) begin
      x_values_d = x_shadow_q;
      y_values_d = y_shadow_q;
    end
    commit_d = (commit_q & ~vblank_start) | wr_commit;
    frame_d  = frame_q + {31'b0, vblank_start};
    done_d   = done_q | wr_done;
    ovf_d    = (ovf_q & ~rd_status) | btn_drop;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_sel_q   <= 1'b0;
      io_rdata_q <= '0;
      x_shadow_q <= '0;
      y_shadow_q <= '0;
      x_values_q <= '0;
      y_values_q <= '0;
      frame_q    <= '0;
      done_q     <= 1'b0;
      commit_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      io_sel_q   <= io_sel_d;
      io_rdata_q <= io_rdata_d;
      x_shadow_q <= x_shadow_d;
      y_shadow_q <= y_shadow_d;
      x_values_q <= x_values_d;
      y_values_q <= y_values_d;
      frame_q    <= frame_d;
      done_q     <= done_d;
      commit_q   <= commit_d;
      ovf_q      <= ovf_d;
    end
  end

  assign q_dmem    = io_sel_q ? io_rdata_q : ram_q;
  assign x_values  = x_values_q;
  assign y_values  = y_values_q;
  assign game_done = done_q;

endmodule

// File: tb/tb_mmio_controller.sv
// Self-checking bench for mmio_controller against a queue-based behavioural model.
module tb_mmio_controller;

  localparam int unsigned BTN_DEPTH = 4;
`ifdef MMIO_BTN_FIFO_EN
  localparam int M_DEPTH = BTN_DEPTH;
  localparam bit M_FIFO  = 1'b1;
`else
  localparam int M_DEPTH = 1;
  localparam bit M_FIFO  = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, wren, mem_read, button_valid, vblank_start;
  logic [11:0] address_dmem;
  logic [31:0] data, ram_q;
  logic [2:0]  button_code;
  logic        ram_wren, game_done;
  logic [31:0] q_dmem, x_values, y_values;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          mq[$];
  bit          m_ovf, m_pend, m_done;
  logic [31:0] m_xs, m_ys, m_xv, m_yv, m_frame;

  mmio_controller #(.BTN_DEPTH(BTN_DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .mem_read     (mem_read),
    .address_dmem (address_dmem),
    .data         (data),
    .ram_q        (ram_q),
    .ram_wren     (ram_wren),
    .q_dmem       (q_dmem),
    .button_code  (button_code),
    .button_valid (button_valid),
    .vblank_start (vblank_start),
    .x_values     (x_values),
    .y_values     (y_values),
    .game_done    (game_done)
  );

  always #5 clock = ~clock;

  function automatic bit is_io(input logic [11:0] a);
    return (a <= 12'd4) || (a == 12'd300) || (a == 12'd400);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovf = 0; m_pend = 0; m_done = 0;
    m_xs = 0; m_ys = 0; m_xv = 0; m_yv = 0; m_frame = 0;
  endfunction

  function automatic void model_step(input bit pv, input logic [2:0] code, input bit rd,
                                     input bit wr, input logic [11:0] a, input logic [31:0] wd,
                                     input bit vb, output bit eio, output logic [31:0] erd,
                                     output logic ewren);
    bit dropped = 0;
    eio   = rd && is_io(a);
    ewren = wr && !is_io(a);
    case (a)
      12'd0:   erd = (mq.size() > 0) ? 32'(mq[0]) : 32'd0;
      12'd1:   erd = {31'b0, m_done};
      12'd3:   erd = {24'b0, m_done, m_pend, m_ovf, 4'(mq.size()), mq.size() > 0};
      12'd4:   erd = m_frame;
      12'd300: erd = m_xs;
      12'd400: erd = m_ys;
      default: erd = 32'd0;
    endcase
    if (rd && a == 12'd0 && mq.size() > 0) void'(mq.pop_front());
    if (pv && code != 3'd0) begin
      if (mq.size() < M_DEPTH) mq.push_back(int'(code));
      else begin
        dropped = 1;
        if (!M_FIFO) mq[0] = int'(code);
      end
    end
    if (rd && a == 12'd3) m_ovf = 0;
    if (dropped) m_ovf = 1;
    if (vb && m_pend) begin m_xv = m_xs; m_yv = m_ys; m_pend = 0; end
    if (wr && a == 12'd2) m_pend = 1;
    if (vb) m_frame = m_frame + 1;
    if (wr && a == 12'd1 && wd[0]) m_done = 1;
    if (wr && a == 12'd300) m_xs = wd;
    if (wr && a == 12'd400) m_ys = wd;
  endfunction

  task automatic clear_inputs();
    button_valid = 0; button_code = 0; mem_read = 0; wren = 0;
    address_dmem = 0; data = 0; vblank_start = 0;
  endtask

  // One bus cycle: drive at negedge, sample ram_wren mid-cycle, sample q_dmem after posedge.
  task automatic run_cycle(input bit pv, input logic [2:0] code, input bit rd, input bit wr,
                           input logic [11:0] a, input logic [31:0] wd, input bit vb,
                           output logic [31:0] gq, output logic [31:0] eq,
                           output logic gw, output logic ew);
    bit eio;
    logic [31:0] erd;
    @(negedge clock);
    button_valid = pv; button_code = code; mem_read = rd; wren = wr;
    address_dmem = a; data = wd; vblank_start = vb; ram_q = $urandom;
    #1 gw = ram_wren;
    model_step(pv, code, rd, wr, a, wd, vb, eio, erd, ew);
    @(posedge clock);
    #1 gq = q_dmem;
    eq = eio ? erd : ram_q;
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_inputs();
    reset = 1;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    logic [31:0] gq, eq; logic gw, ew;
    logic [11:0] addrs [5];
    addrs = '{12'd3, 12'd4, 12'd300, 12'd400, 12'd0};
    do_reset();
    ram_q = $urandom;
    #1;
    n_cmp++; if (q_dmem !== ram_q) begin n_bad++; $display("FAIL reset_qdmem got %h exp %h", q_dmem, ram_q); end
    n_cmp++; if ({x_values, y_values, game_done} !== 65'd0) begin n_bad++; $display("FAIL reset_outputs got %h %h %b exp 0", x_values, y_values, game_done); end
    foreach (addrs[i]) begin
      run_cycle(0, 0, 1, 0, addrs[i], 0, 0, gq, eq, gw, ew);
      n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL reset_read[%0d] got %h exp %h", addrs[i], gq, eq); end
    end
  endtask

  task automatic test_btn_order();
    logic [31:0] gq, eq; logic gw, ew;
    logic [2:0] codes [3];
    codes = '{3'd3, 3'd1, 3'd4};
    foreach (codes[i]) run_cycle(1, codes[i], 0, 0, 12'd20, 0, 0, gq, eq, gw, ew);
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 0, 1, 0, 12'd3, 0, 0, gq, eq, gw, ew);
      n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL btn_status[%0d] got %h exp %h", i, gq, eq); end
      run_cycle(0, 0, 1, 0, 12'd0, 0, 0, gq, eq, gw, ew);
      n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL btn_pop[%0d] got %h exp %h", i, gq, eq); end
    end
    // code 0 must not enqueue
    run_cycle(1, 0, 0, 0, 12'd20, 0, 0, gq, eq, gw, ew);
    run_cycle(0, 0, 1, 0, 12'd3, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL btn_zero_code got %h exp %h", gq, eq); end
  endtask

  task automatic test_overflow();
    logic [31:0] gq, eq; logic gw, ew;
    for (int i = 1; i <= 5; i++) run_cycle(1, 3'(i), 0, 0, 12'd20, 0, 0, gq, eq, gw, ew);
    for (int i = 0; i < 2; i++) begin
      run_cycle(0, 0, 1, 0, 12'd3, 0, 0, gq, eq, gw, ew);
      n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL ovf_status[%0d] got %h exp %h", i, gq, eq); end
    end
    // simultaneous push and pop while full
    run_cycle(1, 3'd7, 1, 0, 12'd0, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL ovf_pushpop got %h exp %h", gq, eq); end
    run_cycle(0, 0, 1, 0, 12'd3, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL ovf_pushpop_status got %h exp %h", gq, eq); end
    for (int i = 0; i < 5; i++) begin
      run_cycle(0, 0, 1, 0, 12'd0, 0, 0, gq, eq, gw, ew);
      n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL ovf_pop[%0d] got %h exp %h", i, gq, eq); end
    end
  endtask

  task automatic test_commit();
    logic [31:0] gq, eq; logic gw, ew;
    run_cycle(0, 0, 0, 1, 12'd300, 32'h0064_0032, 0, gq, eq, gw, ew);
    run_cycle(0, 0, 1, 1, 12'd400, 32'h00C8_0010, 0, gq, eq, gw, ew);
    run_cycle(0, 0, 1, 0, 12'd300, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL shadow_x_read got %h exp %h", gq, eq); end
    run_cycle(0, 0, 0, 1, 12'd2, 0, 0, gq, eq, gw, ew);
    run_cycle(0, 0, 1, 0, 12'd3, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL commit_pending_status got %h exp %h", gq, eq); end
    for (int i = 0; i < 2; i++) begin
      run_cycle(0, 0, 0, 0, 12'd20, 0, 1, gq, eq, gw, ew);
      n_cmp++; if ({x_values, y_values} !== {m_xv, m_yv}) begin n_bad++; $display("FAIL commit_vblank[%0d] got %h %h exp %h %h", i, x_values, y_values, m_xv, m_yv); end
    end
    run_cycle(0, 0, 1, 0, 12'd3, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL commit_clear_status got %h exp %h", gq, eq); end
  endtask

  task automatic test_commit_coincident();
    logic [31:0] gq, eq; logic gw, ew;
    run_cycle(0, 0, 0, 1, 12'd300, 32'h1111_2222, 0, gq, eq, gw, ew);
    run_cycle(0, 0, 0, 1, 12'd400, 32'h3333_4444, 0, gq, eq, gw, ew);
    run_cycle(0, 0, 0, 1, 12'd2, 0, 1, gq, eq, gw, ew);
    n_cmp++; if ({x_values, y_values} !== {m_xv, m_yv}) begin n_bad++; $display("FAIL coincident_hold got %h %h exp %h %h", x_values, y_values, m_xv, m_yv); end
    run_cycle(0, 0, 0, 0, 12'd20, 0, 1, gq, eq, gw, ew);
    n_cmp++; if ({x_values, y_values} !== {m_xv, m_yv}) begin n_bad++; $display("FAIL coincident_next got %h %h exp %h %h", x_values, y_values, m_xv, m_yv); end
  endtask

  task automatic test_game_done();
    logic [31:0] gq, eq; logic gw, ew;
    run_cycle(0, 0, 0, 1, 12'd1, 32'd1, 0, gq, eq, gw, ew);
    run_cycle(0, 0, 0, 1, 12'd1, 32'd0, 0, gq, eq, gw, ew);
    n_cmp++; if (game_done !== m_done) begin n_bad++; $display("FAIL done_sticky got %b exp %b", game_done, m_done); end
    run_cycle(0, 0, 0, 1, 12'd300, 32'hABCD, 0, gq, eq, gw, ew);
    n_cmp++; if (gw !== ew) begin n_bad++; $display("FAIL wren_io got %b exp %b", gw, ew); end
    run_cycle(0, 0, 0, 1, 12'd10, 32'h1234, 0, gq, eq, gw, ew);
    n_cmp++; if (gw !== ew) begin n_bad++; $display("FAIL wren_ram got %b exp %b", gw, ew); end
    run_cycle(0, 0, 0, 1, 12'd3, 32'hFF, 0, gq, eq, gw, ew);
    run_cycle(1, 3'd5, 0, 1, 12'd2, 0, 1, gq, eq, gw, ew);
    // asynchronous reset mid-operation
    @(negedge clock);
    reset = 1;
    #1;
    n_cmp++; if ({game_done, x_values, y_values} !== 65'd0) begin n_bad++; $display("FAIL async_reset got %b %h %h exp 0", game_done, x_values, y_values); end
    model_reset();
    @(negedge clock);
    reset = 0;
    run_cycle(0, 0, 1, 0, 12'd3, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL reset_status got %h exp %h", gq, eq); end
  endtask

  task automatic test_frame();
    logic [31:0] gq, eq; logic gw, ew;
    do_reset();
    repeat (3) run_cycle(0, 0, 0, 0, 12'd20, 0, 1, gq, eq, gw, ew);
    run_cycle(0, 0, 1, 0, 12'd4, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL frame_count got %h exp %h", gq, eq); end
    @(negedge clock);
    force dut.frame_q = 32'hFFFF_FFFF;
    m_frame = 32'hFFFF_FFFF;
    run_cycle(0, 0, 1, 0, 12'd4, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL frame_preload got %h exp %h", gq, eq); end
    release dut.frame_q;
    run_cycle(0, 0, 0, 0, 12'd20, 0, 1, gq, eq, gw, ew);
    run_cycle(0, 0, 1, 0, 12'd4, 0, 0, gq, eq, gw, ew);
    n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL frame_wrap got %h exp %h", gq, eq); end
  endtask

  task automatic test_random();
    logic [31:0] gq, eq; logic gw, ew;
    logic [11:0] alist [9];
    alist = '{12'd0, 12'd0, 12'd1, 12'd2, 12'd3, 12'd4, 12'd300, 12'd400, 12'd10};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      run_cycle($urandom_range(0, 2) == 0, 3'($urandom), $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, alist[$urandom_range(0, 8)],
                ($urandom_range(0, 7) == 0) ? 32'd1 : ($urandom & 32'hFFFF_FFFE),
                $urandom_range(0, 7) == 0, gq, eq, gw, ew);
      n_cmp++; if (gq !== eq) begin n_bad++; $display("FAIL rand_q[%0d] got %h exp %h", i, gq, eq); end
      n_cmp++; if (gw !== ew) begin n_bad++; $display("FAIL rand_wren[%0d] got %b exp %b", i, gw, ew); end
      n_cmp++;
      if ({x_values, y_values, game_done} !== {m_xv, m_yv, m_done}) begin
        n_bad++;
        $display("FAIL rand_out[%0d] got %h %h %b exp %h %h %b", i, x_values, y_values, game_done, m_xv, m_yv, m_done);
      end
    end
  endtask

  initial begin
    reset = 1;
    ram_q = 0;
    clear_inputs();
    model_reset();
    test_reset();
    test_btn_order();
    test_overflow();
    test_commit();
    test_commit_coincident();
    test_game_done();
    test_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
